// File: rtl/sys_issue_ctrl.sv
// sys_issue_ctrl: issue/completion controller for the serialized system RS.
// It takes one request from the system reservation station and holds it until
// that entry reaches the ROB head. It then starts the system FU and waits for
// completion, giving up after a bounded number of cycles.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   Stall, Flush      pipeline stall / flush
//   Kill_Enable       branch mispredict kill, qualified by FUBR_SpecTag
//   Update_KillMask   branch resolved correct; drop FUBR_SpecTag bits from mask
//   FUBR_SpecTag      resolving branch tag
//   Req_Valid/RobIdx/KillMask   system RS request
//   Rob_HeadValid/HeadIdx       ROB head entry
//   Fu_Ready, Fu_Done           system FU handshake
//   Issued_Valid      issue confirmation to RS; doubles as FU start
//   Fu_Abort          abort pulse to FU (flush or timeout while running)
//   Busy              controller not idle
//   Timeout_Err       completion timeout pulse
//   Cur_RobIdx        last captured ROB index
module sys_issue_ctrl #(
    parameter int ROB_W  = 6,
    parameter int SPEC_W = 4,
    parameter int TO_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              Kill_Enable,
    input  logic              Update_KillMask,
    input  logic [SPEC_W-1:0] FUBR_SpecTag,
    input  logic              Req_Valid,
    input  logic [ROB_W-1:0]  Req_RobIdx,
    input  logic [SPEC_W-1:0] Req_KillMask,
    input  logic              Rob_HeadValid,
    input  logic [ROB_W-1:0]  Rob_HeadIdx,
    input  logic              Fu_Ready,
    input  logic              Fu_Done,
    output logic              Issued_Valid,
    output logic              Fu_Abort,
    output logic              Busy,
    output logic              Timeout_Err,
    output logic [ROB_W-1:0]  Cur_RobIdx
);

    typedef enum logic [1:0] {IDLE, WAIT_HEAD, WAIT_DONE} state_t;

    // The counter is cleared on issue and sits at k-1 in the k-th WAIT_DONE
    // cycle. The timeout fires in the cycle whose increment would reach the
    // all-ones terminal count. The FU therefore gets 2^TO_W-1 cycles to finish.
    localparam logic [TO_W-1:0] TO_PRE = {{(TO_W-1){1'b1}}, 1'b0};

    state_t            state, state_nxt;
    logic [TO_W-1:0]   cnt, cnt_nxt;
    logic [ROB_W-1:0]  cap_idx, cap_idx_nxt;
    logic [SPEC_W-1:0] cap_mask, cap_mask_nxt;

    logic kill_req;   // kill hitting the incoming request
    logic kill_cap;   // kill hitting the captured entry
    logic head_hit;

    assign kill_req = Kill_Enable && |(FUBR_SpecTag & Req_KillMask);
    assign kill_cap = Kill_Enable && |(FUBR_SpecTag & cap_mask);
    assign head_hit = Rob_HeadValid && (Rob_HeadIdx == cap_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_idx  <= '0;
            cap_mask <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cap_idx  <= cap_idx_nxt;
            cap_mask <= cap_mask_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cap_idx_nxt  = cap_idx;
        cap_mask_nxt = cap_mask;
        Issued_Valid = 1'b0;
        Fu_Abort     = 1'b0;
        Timeout_Err  = 1'b0;

        case (state)
            IDLE: begin
                if (Req_Valid && !Stall && !Flush && !kill_req) begin
                    cap_idx_nxt  = Req_RobIdx;
                    cap_mask_nxt = Req_KillMask;
                    state_nxt    = WAIT_HEAD;
                end
            end
            WAIT_HEAD: begin
                if (Update_KillMask)
                    cap_mask_nxt = cap_mask & ~FUBR_SpecTag;
                if (Flush || kill_cap || !Req_Valid) begin
                    state_nxt = IDLE;
                end else if (head_hit && Fu_Ready && !Stall) begin
                    Issued_Valid = 1'b1;
                    cnt_nxt      = '0;
                    state_nxt    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // Flush outranks Fu_Done, and Fu_Done outranks the timeout.
                if (Flush) begin
                    Fu_Abort  = 1'b1;
                    state_nxt = IDLE;
                end else if (Fu_Done) begin
                    state_nxt = IDLE;
                end else if (cnt == TO_PRE) begin
                    Timeout_Err = 1'b1;
                    Fu_Abort    = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt + TO_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Reset silences every pulse, including an abort from WAIT_DONE.
        if (rst) begin
            Issued_Valid = 1'b0;
            Fu_Abort     = 1'b0;
            Timeout_Err  = 1'b0;
        end
    end

    assign Busy       = !rst && (state != IDLE);
    assign Cur_RobIdx = rst ? '0 : cap_idx;

endmodule

// File: tb/tb_sys_issue_ctrl.sv
module tb_sys_issue_ctrl;
    localparam int ROB_W = 6, SPEC_W = 4, TO_W = 4;

    logic clk = 0, rst = 1;
    logic Stall = 0, Flush = 0, Kill_Enable = 0, Update_KillMask = 0;
    logic [SPEC_W-1:0] FUBR_SpecTag = '0, Req_KillMask = '0;
    logic Req_Valid = 0, Rob_HeadValid = 0, Fu_Ready = 0, Fu_Done = 0;
    logic [ROB_W-1:0] Req_RobIdx = '0, Rob_HeadIdx = '0;
    logic Issued_Valid, Fu_Abort, Busy, Timeout_Err;
    logic [ROB_W-1:0] Cur_RobIdx;

    sys_issue_ctrl #(.ROB_W(ROB_W), .SPEC_W(SPEC_W), .TO_W(TO_W)) dut (
        .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush),
        .Kill_Enable(Kill_Enable), .Update_KillMask(Update_KillMask),
        .FUBR_SpecTag(FUBR_SpecTag), .Req_Valid(Req_Valid),
        .Req_RobIdx(Req_RobIdx), .Req_KillMask(Req_KillMask),
        .Rob_HeadValid(Rob_HeadValid), .Rob_HeadIdx(Rob_HeadIdx),
        .Fu_Ready(Fu_Ready), .Fu_Done(Fu_Done),
        .Issued_Valid(Issued_Valid), .Fu_Abort(Fu_Abort), .Busy(Busy),
        .Timeout_Err(Timeout_Err), .Cur_RobIdx(Cur_RobIdx)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int iss_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an entry is either waiting for the ROB head
    // or running on the FU. While it runs, age counts the completed run cycles.
    bit m_held = 0, m_run = 0;
    int m_age = 0;
    int m_idx = 0, m_mask = 0;
    bit n_held, n_run;
    int n_age, n_idx, n_mask;
    localparam int RUN_LIMIT = (1 << TO_W) - 1;   // run cycles before giving up

    always @(negedge clk) begin
        bit kc, kr, e_iss, e_to, e_ab;
        kc = Kill_Enable && ((FUBR_SpecTag & m_mask[SPEC_W-1:0]) != 0);
        kr = Kill_Enable && ((FUBR_SpecTag & Req_KillMask) != 0);
        e_iss = m_held && Req_Valid && Rob_HeadValid && (Rob_HeadIdx == m_idx[ROB_W-1:0])
                && Fu_Ready && !Stall && !Flush && !kc;
        e_to  = m_run && !Flush && !Fu_Done && (m_age + 1 == RUN_LIMIT);
        e_ab  = m_run && (Flush || e_to);
        if (rst) begin
            e_iss = 0; e_to = 0; e_ab = 0;
        end
        chk("issued", Issued_Valid, e_iss);
        chk("abort", Fu_Abort, e_ab);
        chk("timeout", Timeout_Err, e_to);
        chk("busy", Busy, rst ? 0 : (m_held || m_run));
        chk("cur_idx", Cur_RobIdx, rst ? 0 : m_idx);
        if (Issued_Valid) iss_cnt++;

        n_held = m_held; n_run = m_run; n_age = m_age; n_idx = m_idx; n_mask = m_mask;
        if (rst) begin
            n_held = 0; n_run = 0; n_age = 0; n_idx = 0; n_mask = 0;
        end else if (Flush) begin
            n_held = 0; n_run = 0;
        end else if (m_run) begin
            if (Fu_Done || e_to) n_run = 0;
            else n_age = m_age + 1;
        end else if (m_held) begin
            if (Update_KillMask) n_mask = m_mask & ~int'(FUBR_SpecTag);
            if (kc || !Req_Valid) n_held = 0;
            else if (e_iss) begin n_held = 0; n_run = 1; n_age = 0; end
        end else if (Req_Valid && !Stall && !kr) begin
            n_held = 1; n_idx = Req_RobIdx; n_mask = Req_KillMask;
        end
    end

    always @(posedge clk) begin
        m_held <= n_held; m_run <= n_run; m_age <= n_age;
        m_idx <= n_idx; m_mask <= n_mask;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base, to_at, to_n, ab_at;
        // reset has priority over flush and request
        Flush = 1; Req_Valid = 1; Req_RobIdx = 6'd9;
        tick(2);
        #1 chk("rst_busy", Busy, 0);
        chk("rst_cur", Cur_RobIdx, 0);
        rst = 0; Flush = 0; Req_Valid = 0;
        tick();

        // head mismatch for 4 cycles, then match: one issue pulse
        Req_Valid = 1; Req_RobIdx = 6'd5; Req_KillMask = '0;
        Rob_HeadValid = 1; Rob_HeadIdx = 6'd3; Fu_Ready = 1;
        tick();
        base = iss_cnt;
        #1 chk("h22_busy", Busy, 1);
        chk("h22_noiss", Issued_Valid, 0);
        tick(3);
        Rob_HeadIdx = 6'd5;
        #1 chk("h22_iss", Issued_Valid, 1);
        tick();
        Req_Valid = 0;
        #1 chk("h22_iss_once", Issued_Valid, 0);
        tick(3);
        chk("h22_busy_run", Busy, 1);
        Fu_Done = 1;
        tick();
        Fu_Done = 0;
        #1 chk("h22_idle", Busy, 0);
        chk("h22_cur", Cur_RobIdx, 5);
        chk("h22_count", iss_cnt - base, 1);

        // kill hit while waiting for head
        Req_Valid = 1; Req_RobIdx = 6'd7; Req_KillMask = 4'b0010; Rob_HeadIdx = 6'd0;
        tick();
        Kill_Enable = 1; FUBR_SpecTag = 4'b0010;
        #1 chk("h23_noiss", Issued_Valid, 0);
        tick();
        Kill_Enable = 0; Req_Valid = 0;
        #1 chk("h23_idle", Busy, 0);
        chk("h23_cur", Cur_RobIdx, 7);

        // kill hit on the incoming request blocks capture
        Req_Valid = 1; Req_RobIdx = 6'd9; Req_KillMask = 4'b0100;
        Kill_Enable = 1; FUBR_SpecTag = 4'b0100;
        tick();
        Kill_Enable = 0; Req_Valid = 0;
        #1 chk("kreq_idle", Busy, 0);
        chk("kreq_cur", Cur_RobIdx, 7);

        // resolved-correct branch clears the tag, so the later kill misses
        Req_Valid = 1; Req_RobIdx = 6'd2; Req_KillMask = 4'b0010; Rob_HeadIdx = 6'd0;
        tick();
        Update_KillMask = 1; FUBR_SpecTag = 4'b0010;
        tick();
        Update_KillMask = 0; Kill_Enable = 1;
        tick();
        Kill_Enable = 0;
        #1 chk("h24_alive", Busy, 1);
        Rob_HeadIdx = 6'd2;
        #1 chk("h24_iss", Issued_Valid, 1);
        tick();
        Req_Valid = 0; Fu_Done = 1;
        tick();
        Fu_Done = 0;
        #1 chk("h24_idle", Busy, 0);

        // timeout on the 15th run cycle
        Req_Valid = 1; Req_RobIdx = 6'd4; Req_KillMask = '0; Rob_HeadIdx = 6'd4;
        tick(2);
        Req_Valid = 0;
        to_at = 0; to_n = 0; ab_at = 0;
        for (int k = 1; k <= 20; k++) begin
            #1;
            if (Timeout_Err) begin to_at = k; to_n++; end
            if (Fu_Abort) ab_at = k;
            tick();
        end
        chk("h25_at", to_at, 15);
        chk("h25_n", to_n, 1);
        chk("h25_abort", ab_at, 15);
        chk("h25_idle", Busy, 0);

        // Fu_Done in the terminal cycle wins over the timeout
        Req_Valid = 1;
        tick(2);
        Req_Valid = 0;
        tick(14);
        Fu_Done = 1;
        #1 chk("h13_noto", Timeout_Err, 0);
        chk("h13_noab", Fu_Abort, 0);
        tick();
        Fu_Done = 0;
        #1 chk("h13_idle", Busy, 0);

        // stall holds off the issue; flush in the run state aborts
        Req_Valid = 1; Req_RobIdx = 6'd6; Rob_HeadIdx = 6'd0;
        tick();
        base = iss_cnt;
        Rob_HeadIdx = 6'd6; Stall = 1;
        tick(3);
        chk("h26_stall", iss_cnt - base, 0);
        Stall = 0;
        #1 chk("h26_iss", Issued_Valid, 1);
        tick();
        Req_Valid = 0; Stall = 1;
        tick(2);
        Flush = 1; Fu_Done = 1;
        #1 chk("h26_abort", Fu_Abort, 1);
        tick();
        Flush = 0; Fu_Done = 0; Stall = 0;
        #1 chk("h26_idle", Busy, 0);
        chk("h26_noab", Fu_Abort, 0);
        chk("h26_count", iss_cnt - base, 1);

        // reset while running gives no abort
        Req_Valid = 1; Req_RobIdx = 6'd1; Rob_HeadIdx = 6'd1;
        tick(2);
        Req_Valid = 0;
        tick();
        rst = 1;
        #1 chk("h21_noab", Fu_Abort, 0);
        chk("h21_busy", Busy, 0);
        tick();
        rst = 0;
        #1 chk("h21_cur", Cur_RobIdx, 0);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sys_issue_ctrl.md
SYS_ISSUE_CTRL -- requirements
Module: sys_issue_ctrl

Interface
REQ-001 SHALL have parameter ROB_W, default 6, ROB index width.
REQ-002 SHALL have parameter SPEC_W, default 4, speculative-tag/kill-mask width.
REQ-003 SHALL have parameter TO_W, default 10, completion-timeout counter width.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- Stall  in  1  pipeline stall; system RS holds.
- Flush  in  1  pipeline flush.
- Kill_Enable  in  1  branch mispredict kill.
- Update_KillMask  in  1  branch resolved correct; clear tag bits.
- FUBR_SpecTag  in  SPEC_W  resolving branch tag.
- Req_Valid  in  1  system RS issue request valid.
- Req_RobIdx  in  ROB_W  ROB index of the requesting entry.
- Req_KillMask  in  SPEC_W  kill mask of the requesting entry.
- Rob_HeadValid  in  1  ROB head entry valid.
- Rob_HeadIdx  in  ROB_W  ROB head index.
- Fu_Ready  in  1  system FU able to accept.
- Fu_Done  in  1  system FU completion pulse.
- Issued_Valid  out  1  issue confirmation to system RS; also FU start.
- Fu_Abort  out  1  abort pulse to system FU.
- Busy  out  1  controller not idle; dispatch serialization.
- Timeout_Err  out  1  completion timeout pulse.
- Cur_RobIdx  out  ROB_W  captured ROB index.

Function
REQ-005 SHALL implement a state machine with states IDLE, WAIT_HEAD and WAIT_DONE.
REQ-006 In IDLE, when Req_Valid=1, ~Stall and ~Flush, the block SHALL capture Req_RobIdx and Req_KillMask and move to WAIT_HEAD.
- If Kill_Enable=1 and |(FUBR_SpecTag & Req_KillMask) in that cycle, the block SHALL NOT capture and SHALL stay in IDLE.
REQ-007 In WAIT_HEAD, a kill hit (Kill_Enable & |(FUBR_SpecTag & captured mask)) SHALL return the block to IDLE with no issue.
REQ-008 In WAIT_HEAD, when Update_KillMask=1, the captured mask SHALL become mask & ~FUBR_SpecTag.
REQ-009 Issued_Valid SHALL be combinational and high only when all hold:
- state is WAIT_HEAD;
- Req_Valid=1;
- Rob_HeadValid=1;
- Rob_HeadIdx equals the captured index;
- Fu_Ready=1;
- ~Stall, ~Flush, and no kill hit.
REQ-010 Issued_Valid SHALL last exactly one cycle per instruction; the next state SHALL be WAIT_DONE and the timeout counter SHALL clear to 0.
REQ-011 In WAIT_HEAD, if Req_Valid drops (entry killed externally), the block SHALL return to IDLE.
REQ-012 In WAIT_DONE:
- Fu_Done=1 SHALL move the block to IDLE.
- Otherwise the counter SHALL increment by 1 per cycle, including during Stall.
- At count 2^TO_W-1 without Fu_Done, Timeout_Err SHALL pulse for one cycle, Fu_Abort SHALL pulse for one cycle, and the block SHALL move to IDLE.
REQ-013 If Fu_Done and the terminal count occur in the same cycle, Fu_Done SHALL take priority and no Timeout_Err SHALL be raised.
REQ-014 Flush SHALL force IDLE at the next edge from any state.
- Flush in WAIT_DONE SHALL pulse Fu_Abort for one cycle, combinationally in that cycle.
- Flush SHALL override Fu_Done.
REQ-015 Stall SHALL block the IDLE->WAIT_HEAD and WAIT_HEAD->WAIT_DONE transitions only; kill and flush SHALL act during Stall.
REQ-016 Busy SHALL be 1 whenever state is not IDLE.
REQ-017 Cur_RobIdx SHALL hold the last captured value until the next capture.
REQ-018 ROB index compare SHALL be exact equality over ROB_W bits, with no wrap arithmetic.

Reset
REQ-019 On rst=1 at the clock edge, state SHALL become IDLE, and the counter, captured index and captured mask SHALL become 0.
REQ-020 During and after reset, Issued_Valid, Fu_Abort, Timeout_Err and Busy SHALL be 0 and Cur_RobIdx SHALL be 0; rst SHALL take priority over Flush.
REQ-021 rst asserted in WAIT_DONE SHALL NOT pulse Fu_Abort.

Verification
REQ-022 Req_Valid=1, Req_RobIdx=5, Rob_HeadIdx=3 for 4 cycles then 5, Fu_Ready=1 -> Issued_Valid=1 for exactly one cycle, in the first cycle head=5; Busy stays 1 until Fu_Done.
REQ-023 Capture with mask=4'b0010, then Kill_Enable=1 with FUBR_SpecTag=4'b0010 in WAIT_HEAD -> IDLE next cycle; Issued_Valid never asserted.
REQ-024 Mask=4'b0010, Update_KillMask with tag 4'b0010, then Kill_Enable with tag 4'b0010 -> no kill; issue proceeds when head matches.
REQ-025 TO_W=4, issue, never assert Fu_Done -> Timeout_Err and Fu_Abort pulse on the 15th WAIT_DONE cycle, then IDLE.
REQ-026 Head matches while Stall=1 for 3 cycles -> no Issued_Valid until Stall=0, then one pulse; Flush in WAIT_DONE -> Fu_Abort pulse, IDLE, Busy=0.
